// File: rtl/booth_pkg.sv
// Shared constants, FSM state type and radix-4 Booth digit decoding for booth_mul_seq.
package booth_pkg;

    localparam int XLEN = 32;
    localparam int NDIG = XLEN / 2 + 1;
    localparam int AW   = XLEN + 1;     // sign-extended operand width
    localparam int PPW  = XLEN + 3;     // partial product width (holds +/-2*A33)
    localparam int ACCW = 2 * XLEN + 2; // accumulator width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] CODE_Z0  = 3'b000;
    localparam logic [2:0] CODE_P1A = 3'b001;
    localparam logic [2:0] CODE_P1B = 3'b010;
    localparam logic [2:0] CODE_P2  = 3'b011;
    localparam logic [2:0] CODE_M2  = 3'b100;
    localparam logic [2:0] CODE_M1A = 3'b101;
    localparam logic [2:0] CODE_M1B = 3'b110;
    localparam logic [2:0] CODE_Z1  = 3'b111;

    function automatic logic signed [2:0] booth_digit(input logic [2:0] code);
        logic signed [2:0] d;
        case (code)
            CODE_P1A, CODE_P1B: d = 3'sd1;
            CODE_P2:            d = 3'sd2;
            CODE_M2:            d = -3'sd2;
            CODE_M1A, CODE_M1B: d = -3'sd1;
            default:            d = 3'sd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_digit_pp.sv
// Combinational Booth partial product: one 3-bit digit code times the 33-bit multiplicand.
module booth_digit_pp
    import booth_pkg::*;
(
    input  logic [2:0]     code,
    input  logic [AW-1:0]  a33,
    output logic [PPW-1:0] pp
);

    logic [PPW-1:0]    a_ext;
    logic signed [2:0] digit;

    assign a_ext = {{2{a33[AW-1]}}, a33};
    assign digit = booth_digit(code);

    always_comb begin
        pp = '0;
        case (digit)
            3'sd1:   pp = a_ext;
            3'sd2:   pp = a_ext << 1;
            -3'sd1:  pp = -a_ext;
            -3'sd2:  pp = -(a_ext << 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth 32x32 multiplier, one digit per cycle, valid/ready on both sides.
// Define EARLY_TERM_EN to finish as soon as the remaining multiplier digits are all zero.
module booth_mul_seq
    import booth_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    input  logic                a_signed,
    input  logic                b_signed,
    input  logic                flush,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*XLEN-1:0]   product
);

    state_t              state, state_next;
    logic [4:0]          cnt, cnt_next;
    logic [AW-1:0]       a33, a33_next, b33, b33_next;
    logic [ACCW-1:0]     acc, acc_next, pp_shifted;
    logic [2*XLEN-1:0]   product_next;
    logic [AW+1:0]       bx;
    logic [2:0]          code;
    logic [PPW-1:0]      pp;
    logic                early;

    // bx[i] holds Booth index i-1, so digit j reads bx[2j+2:2j]
    assign bx   = {b33[AW-1], b33, 1'b0};
    assign code = bx[{cnt, 1'b0} +: 3];

    booth_digit_pp u_pp (
        .code (code),
        .a33  (a33),
        .pp   (pp)
    );

    assign pp_shifted = {{(ACCW-PPW){pp[PPW-1]}}, pp} << {cnt, 1'b0};

`ifdef EARLY_TERM_EN
    logic [5:0]    sh;
    logic [AW-1:0] rest, ones;

    // Remaining digits are all zero when B33[32:2j-1] is a pure sign run
    assign sh    = {cnt, 1'b0} - 6'd1;
    assign rest  = b33 >> sh;
    assign ones  = {AW{1'b1}} >> sh;
    assign early = (cnt != '0) && ((rest == '0) || (rest == ones));
`else
    assign early = 1'b0;
`endif

    assign in_ready = (state == IDLE);

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        a33_next     = a33;
        b33_next     = b33;
        acc_next     = acc;
        product_next = product;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a33_next   = {a_signed & a[XLEN-1], a};
                    b33_next   = {b_signed & b[XLEN-1], b};
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (early) begin
                    product_next = acc[2*XLEN-1:0];
                    state_next   = DONE;
                end else begin
                    acc_next = acc + pp_shifted;
                    cnt_next = cnt + 5'd1;
                    if (cnt == 5'(NDIG - 1)) begin
                        product_next = acc_next[2*XLEN-1:0];
                        state_next   = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a33       <= '0;
            b33       <= '0;
            acc       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            a33       <= a33_next;
            b33       <= b33_next;
            acc       <= acc_next;
            product   <= product_next;
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed vector table, abort sequences, random sweep.
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        a_signed = 1'b0;
    logic        b_signed = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] product;

    int checks = 0;
    int errors = 0;

    booth_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .flush     (flush),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          as;
        bit          bs;
        int          stall;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                             input bit xs, input bit ys);
        longint sx, sy;
        sx = xs ? longint'(signed'(x)) : longint'({32'b0, x});
        sy = ys ? longint'(signed'(y)) : longint'({32'b0, y});
        return sx * sy;
    endfunction

    // Edges after the accept edge until out_valid is seen high
    function automatic int ref_lat(input logic [31:0] y, input bit ys);
`ifdef EARLY_TERM_EN
        longint v, t;
        v = ys ? longint'(signed'(y)) : longint'({32'b0, y});
        for (int j = 1; j < 17; j++) begin
            t = v >>> (2 * j - 1);
            if (t == 0 || t == -1) return j + 1;
        end
`else
        if (ys) return 17;
`endif
        return 17;
    endfunction

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input bit xs, input bit ys,
                          input int stall, input bit noise,
                          output logic [63:0] p, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("idle_before_accept", in_ready, 1);
        a = x; b = y; a_signed = xs; b_signed = ys;
        in_valid = 1'b1;
        step();
        in_valid = noise;
        check("busy_after_accept", {busy, in_ready, out_valid}, 3'b100);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (noise) begin
                a = $urandom; b = $urandom;
                a_signed = 1'($urandom); b_signed = 1'($urandom);
            end
            step();
            lat++;
            check("no_accept_while_busy", {busy, in_ready}, 2'b10);
        end
        p = product;
        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_valid", {out_valid, in_ready}, 2'b10);
            check("stall_product", product, p);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("valid_drop", {out_valid, busy, in_ready}, 3'b001);
    endtask

    task automatic abort_at8(input bit use_rst, input bit use_flush, input string tag);
        logic [63:0] p;
        int lat, rises;
        while (!in_ready) step();
        a = 32'h12345678; b = 32'h9abcdef0; a_signed = 1'b1; b_signed = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        rst = use_rst; flush = use_flush;
        step();
        rst = 1'b0; flush = 1'b0;
        check({tag, "_idle"}, {busy, in_ready, out_valid}, 3'b010);
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) rises++;
        end
        check({tag, "_no_result"}, rises, 0);
        run_op(32'd7, 32'd6, 1'b0, 1'b0, 0, 1'b0, p, lat);
        check({tag, "_next_product"}, p, 64'd42);
        check({tag, "_next_latency"}, lat, ref_lat(32'd6, 1'b0));
    endtask

    initial begin
        logic [63:0] p;
        int lat, n;
        logic [31:0] x, y;
        bit xs, ys;

        vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 64'hFFFFFFFE00000001};
        vecs[1] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 0, 64'h4000000000000000};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1, 64'h0000000000000001};
        vecs[3] = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 1'b0, 0, 64'hFFFFFFFFFFFFFFFA};
        vecs[4] = '{32'h00000007, 32'h00000006, 1'b0, 1'b0, 5, 64'd42};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 2, 64'hFFFFFFFF00000001};
        vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 1'b1, 0, 64'hC000000000000000};
        vecs[7] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 3, 64'h0};

        step();
        step();
        check("reset_state", {in_ready, busy, out_valid}, 3'b100);
        check("reset_product", product, 64'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].as, vecs[i].bs, vecs[i].stall, 1'b0, p, lat);
            check($sformatf("vec%0d_product", i), p, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, ref_lat(vecs[i].b, vecs[i].bs));
        end

        abort_at8(1'b0, 1'b1, "flush_cnt8");
        abort_at8(1'b1, 1'b0, "rst_cnt8");
        abort_at8(1'b1, 1'b1, "rstflush_cnt8");

        // flush in IDLE blocks a simultaneous accept
        a = 32'd5; b = 32'd5; in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_blocks_accept", {busy, in_ready}, 2'b01);

        // flush wins over out_ready in DONE
        a = 32'd9; b = 32'd9; a_signed = 1'b0; b_signed = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check("done_before_flush", out_valid, 1);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        check("flush_in_done", {out_valid, busy, in_ready}, 3'b001);

        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 5))
                0:       x = 32'h80000000;
                1:       x = 32'hFFFFFFFF;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       y = $urandom_range(0, 15);
                1:       y = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
                default: y = $urandom;
            endcase
            xs = 1'($urandom);
            ys = 1'($urandom);
            run_op(x, y, xs, ys, $urandom_range(0, 3), 1'($urandom), p, lat);
            check("rand_product", p, ref_prod(x, y, xs, ys));
            check("rand_latency", lat, ref_lat(y, ys));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
